// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: accepts two WIDTH-bit operands, adds them LSB-first
// through a single full-adder cell over WIDTH cycles, and holds the result until taken.
module serial_add_seq #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry, cout_r;
  logic [CNT_W-1:0] count;
  logic             last_bit;

  // Full adder built from two half adders and an OR, reused for every bit.
  logic ha0_s, ha0_c, ha1_c, fa_s, fa_c;

  always_comb begin
    ha0_s = a_sh[0] ^ b_sh[0];
    ha0_c = a_sh[0] & b_sh[0];
    fa_s  = ha0_s ^ carry;
    ha1_c = ha0_s & carry;
    fa_c  = ha0_c | ha1_c;
  end

  assign last_bit = (count == CNT_W'(WIDTH - 1));

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
          end
        end
        RUN: begin
          // Sum fills from the top so bit 0 lands in the LSB after WIDTH shifts.
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_c;
          count  <= count + 1'b1;
          if (last_bit) cout_r <= fa_c;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign sum       = sum_sh;
  assign cout      = cout_r;

endmodule
